// File: rtl/dcache_dm_if.sv
// Processor-side request port and word-wide backing-memory port of the data cache.
// The slave modport is the cache's view; master is the pipeline plus memory.
interface dcache_dm_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            mask;
  logic [31:0]           rdata;
  logic                  hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  addr, wdata, mem_read, mem_write, mask, mem_rdata, mem_ack,
    output rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, wdata, mem_read, mem_write, mask, mem_rdata, mem_ack,
    input  rdata, hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-back, write-allocate data cache. Hits complete in the request
// cycle; misses stall on hit while the victim is written back and the line refilled.
module dcache_dm #(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  dcache_dm_if.slave  bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - 2 - WORD_W - IDX_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);
  localparam logic [WORD_W-1:0] BEAT0     = '0;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                  state;
  logic [WORD_W-1:0]       beat;
  logic [NUM_LINES-1:0]    valid_r;
  logic [NUM_LINES-1:0]    dirty_r;
  logic [TAG_W-1:0]        tag_r [NUM_LINES];
  logic [31:0]             data_r [NUM_LINES*LINE_WORDS];
  logic                    mem_req_r;
  logic                    mem_we_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [31:0]             mem_wdata_r;

  logic [1:0]              off;
  logic [WORD_W-1:0]       word;
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [WORD_W-1:0]       beat_nxt;
  logic                    req;
  logic                    lookup;
  logic                    miss;
  logic                    store_en;
  logic                    beat_done;
  logic [31:0]             cur_word;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic store_ok(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b001) || (m == 3'b010);
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] m,
                                           input logic [1:0] o);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{o, 3'b000} +: 8];
    h = w[{o[1], 4'b0000} +: 16];
    case (m)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] m, input logic [1:0] o);
    logic [31:0] r;
    r = w;
    case (m)
      3'b000:  r[{o, 3'b000} +: 8] = d[7:0];
      3'b001:  r[{o[1], 4'b0000} +: 16] = d[15:0];
      3'b010:  r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  assign off      = bus.addr[1:0];
  assign word     = bus.addr[2 +: WORD_W];
  assign idx      = bus.addr[2+WORD_W +: IDX_W];
  assign tag      = bus.addr[ADDR_WIDTH-1 -: TAG_W];
  assign beat_nxt = beat + WORD_W'(1);

  assign req       = bus.mem_read | bus.mem_write;
  assign lookup    = (state == IDLE) && req && valid_r[idx] && (tag_r[idx] == tag);
  assign miss      = (state == IDLE) && req && !lookup;
  assign store_en  = lookup && bus.mem_write && store_ok(bus.mask);
  assign beat_done = mem_req_r && bus.mem_ack;
  assign cur_word  = data_r[{idx, word}];

  assign bus.hit       = lookup;
  assign bus.rdata     = (lookup && bus.mem_read && !bus.mem_write) ?
                         load_ext(cur_word, bus.mask, off) : 32'd0;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // Control: line state, miss FSM, beat registers and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      beat        <= '0;
      valid_r     <= '0;
      dirty_r     <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_r[i] <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      if (lookup) hit_count <= sat_inc(hit_count);
      if (store_en) dirty_r[idx] <= 1'b1;
      case (state)
        IDLE: begin
          if (miss) begin
            miss_count <= sat_inc(miss_count);
            beat       <= '0;
            mem_req_r  <= 1'b1;
            if (valid_r[idx] && dirty_r[idx]) begin
              state       <= WRITEBACK;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= {tag_r[idx], idx, BEAT0, 2'b00};
              mem_wdata_r <= data_r[{idx, BEAT0}];
            end else begin
              state      <= REFILL;
              mem_we_r   <= 1'b0;
              mem_addr_r <= {tag, idx, BEAT0, 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (beat_done) begin
            if (beat == LAST_BEAT) begin
              state      <= REFILL;
              beat       <= '0;
              mem_we_r   <= 1'b0;
              mem_addr_r <= {tag, idx, BEAT0, 2'b00};
            end else begin
              beat        <= beat_nxt;
              mem_addr_r  <= {tag_r[idx], idx, beat_nxt, 2'b00};
              mem_wdata_r <= data_r[{idx, beat_nxt}];
            end
          end
        end
        REFILL: begin
          if (beat_done) begin
            if (beat == LAST_BEAT) begin
              state        <= IDLE;
              beat         <= '0;
              mem_req_r    <= 1'b0;
              valid_r[idx] <= 1'b1;
              dirty_r[idx] <= 1'b0;
              tag_r[idx]   <= tag;
            end else begin
              beat       <= beat_nxt;
              mem_addr_r <= {tag, idx, beat_nxt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data array: store merges on hit, refill beats on ack; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (store_en)
        data_r[{idx, word}] <= store_merge(cur_word, bus.wdata, bus.mask, off);
      if ((state == REFILL) && beat_done)
        data_r[{idx, beat}] <= bus.mem_rdata;
    end
  end
endmodule
